sum_uart_tx: RTL and testbench

SUM_UART_TX -- requirements
Module: sum_uart_tx

---
 rtl/sum_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_sum_uart_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_uart_tx.sv
// UART transmitter fed by a small byte FIFO: buffers result bytes from the
// adder stage and sends them as 8N1 frames back-to-back when available.
module sum_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            bit_end;
  logic            has_data;

  // Ready depends only on registered occupancy, so a pop never frees a slot
  // for the same edge.
  assign in_ready = (level_q != LW'(FIFO_DEPTH)) && !rst;
  assign push     = in_valid && in_ready;
  assign bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign has_data = (level_q != '0);

  assign tx    = tx_q;
  assign level = level_q;
  assign busy  = !rst && ((state_q != IDLE) || has_data);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        bit_d = '0;
        if (has_data) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (has_data) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Scoreboard bench for sum_uart_tx: accepted bytes are queued and compared
// against frames decoded from the serial line.
module tb_sum_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  sum_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .level   (level)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_frames = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  int         fstart[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard producer: every handshake queues the byte; reset discards all.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(in_data);
  end

  // Line monitor: samples two time units after each falling edge.
  initial begin : monitor
    logic [9:0] exp_bits;
    logic [7:0] got_byte;
    int         bad;
    int         bi;
    bit         aborted;
    forever begin
      @(negedge clk); #2;
      if (!rst && tx === 1'b0) begin
        fstart.push_back(cyc);
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) exp_bits = {1'b1, exp_q.pop_front(), 1'b0};
        else exp_bits = 10'b1000000000;
        bad = 0; got_byte = 8'h00; aborted = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
          if (c > 0) begin @(negedge clk); #2; end
          if (rst) begin aborted = 1'b1; break; end
          bi = c / CPB;
          if (tx !== exp_bits[bi]) bad++;
          if ((c % CPB) == 2 && bi >= 1 && bi <= 8) got_byte[bi-1] = tx;
        end
        if (!aborted) begin
          n_frames++;
          check("frame_data", 32'(got_byte), 32'(exp_bits[8:1]));
          check("frame_shape", 32'(bad), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin tick(); n++; end
    check(tag, 32'(busy), 32'd0);
    repeat (3) tick();
  endtask

  initial begin : stim
    int  idx, stalls, guard;
    bit  acc, seen_full;

    // Reset with in_valid asserted: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    rst = 1'b0; in_valid = 1'b0; #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);
    tick();
    check("level_after_rst", 32'(level), 32'd0);
    check("idle_tx", 32'(tx), 32'd1);

    // Single byte 0xA5: latency and frame length.
    in_valid = 1'b1; in_data = 8'hA5;
    tick(); in_valid = 1'b0;
    check("t1_level1", 32'(level), 32'd1);
    check("t1_tx_pre", 32'(tx), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_tx_start", 32'(tx), 32'd0);
    check("t1_level0", 32'(level), 32'd0);
    repeat (FRAME - 1) tick();
    check("t1_busy_last", 32'(busy), 32'd1);
    tick();
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_tx_idle", 32'(tx), 32'd1);
    repeat (3) tick();

    // Back-to-back 0x00, 0xFF: contiguous frames.
    fstart.delete();
    in_valid = 1'b1; in_data = 8'h00; tick();
    in_data = 8'hFF; tick(); in_valid = 1'b0;
    wait_idle(200, "t2_idle");
    check("t2_nframes", 32'(fstart.size()), 32'd2);
    if (fstart.size() == 2) check("t2_gap", 32'(fstart[1] - fstart[0]), 32'(FRAME));

    // Six bytes with in_valid held: backpressure when full.
    fstart.delete();
    idx = 1; stalls = 0; guard = 0; seen_full = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    while (idx <= 6 && guard < 300) begin
      if (in_ready !== 1'b1) begin
        stalls++;
        if (!seen_full) begin
          seen_full = 1'b1;
          check("t3_full_level", 32'(level), 32'd4);
          check("t3_first_stall_idx", 32'(idx), 32'd6);
        end
      end
      acc = (in_ready === 1'b1);
      tick(); guard++;
      if (acc) begin idx++; in_data = 8'(idx); end
    end
    in_valid = 1'b0;
    check("t3_accept_timeout", 32'(idx), 32'd7);
    check("t3_stalls", 32'(stalls), 32'd37);
    wait_idle(400, "t3_idle");
    check("t3_nframes", 32'(fstart.size()), 32'd6);

    // Push on the same edge as a pop with level 2.
    fstart.delete();
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick(); in_valid = 1'b0;
    repeat (FRAME - 2) tick();
    check("t4_level_pre", 32'(level), 32'd2);
    check("t4_tx_stop", 32'(tx), 32'd1);
    in_valid = 1'b1; in_data = 8'h44; tick(); in_valid = 1'b0;
    check("t4_level_same", 32'(level), 32'd2);
    check("t4_tx_start", 32'(tx), 32'd0);
    wait_idle(300, "t4_idle");
    check("t4_nframes", 32'(fstart.size()), 32'd4);

    // Reset during data bit 3 with two bytes still buffered.
    in_valid = 1'b1; in_data = 8'h5C; tick();
    in_data = 8'hC3; tick();
    in_data = 8'h3C; tick(); in_valid = 1'b0;
    repeat (16) tick();
    check("t5_level_pre", 32'(level), 32'd2);
    check("t5_tx_bit3", 32'(tx), 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_level", 32'(level), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    fstart.delete();
    repeat (100) tick();
    check("t5_no_frames", 32'(fstart.size()), 32'd0);
    check("t5_tx_idle", 32'(tx), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("total_frames", 32'(n_frames), 32'd13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
